dmem_responder: RTL

//  Responder (memory) end of the core's data-memory interface: services load/store

---
 rtl/riscv_mem_pkg.sv | 18 +
 rtl/mem_array_be.sv | 35 +++
 rtl/dmem_responder.sv | 126 ++++++++++++
 3 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared types for the data-memory responder.
//   dmem_state_e : responder FSM states
//   WORD_BYTES   : bytes per array word (also the number of byte lanes)
//   mem_req_t    : one captured load/store request
package riscv_mem_pkg;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_e;

   localparam int WORD_BYTES = 4;

   typedef struct packed {
      logic                      we;
      logic [31:0]               addr;
      logic [31:0]               wdata;
      logic [WORD_BYTES-1:0]     be;
   } mem_req_t;

endpackage

// File: rtl/mem_array_be.sv
// DEPTH x 32 storage with synchronous byte-lane writes and combinational read.
// Ports:
//   clk : write clock
//   we  : write strobe; each lane is written only when its be bit is also set
//   be  : per-byte lane enables
//   idx : word index, shared by read and write
//   wd  : write data
//   rd  : read data at idx (combinational)
module mem_array_be
   import riscv_mem_pkg::*;
#(
   parameter int DEPTH = 64,
   parameter int IW    = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [WORD_BYTES-1:0] be,
   input  logic [IW-1:0]         idx,
   input  logic [31:0]           wd,
   output logic [31:0]           rd
);

   // Each byte lane is its own array so a partial store touches only the
   // enabled lanes.
   for (genvar i = 0; i < WORD_BYTES; i++) begin : g_lane
      logic [7:0] lane [DEPTH];

      always_ff @(posedge clk) begin
         if (we && be[i]) lane[idx] <= wd[8*i +: 8];
      end

      assign rd[8*i +: 8] = lane[idx];
   end

endmodule

// File: rtl/dmem_responder.sv
// Memory end of the data-memory valid/ready interface, with a fixed number of
// wait states, byte-lane stores and misaligned/out-of-range error reporting.
// Ports:
//   clk, reset            : clock; asynchronous active-high reset
//   req_valid / req_ready : request handshake (accepted only in IDLE)
//   req_we, req_addr,
//   req_wdata, req_be     : request payload (be used for stores only)
//   rsp_valid / rsp_ready : response handshake (held in RESP until consumed)
//   rsp_rdata, rsp_err    : load data (0 for stores/errors), error flag
module dmem_responder
   import riscv_mem_pkg::*;
#(
   parameter int          DEPTH     = 64,
   parameter int          LATENCY   = 2,
   parameter logic [31:0] BASE_ADDR = 32'h0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int          IW   = $clog2(DEPTH);
   localparam logic [32:0] SPAN = 33'(WORD_BYTES * DEPTH);

   dmem_state_e   state, state_nxt;
   logic [3:0]    cnt;
   mem_req_t      req_q, cur;
   logic          accept, enter_resp, err, mem_we;
   logic [32:0]   off;
   logic [IW-1:0] idx;
   logic [31:0]   rd;

   assign accept = req_valid && req_ready;

   // With zero wait states the access happens on the accept edge itself, so
   // in IDLE the live request is used rather than the capture register.
   always_comb begin
      cur = req_q;
      if (state == IDLE) begin
         cur.we    = req_we;
         cur.addr  = req_addr;
         cur.wdata = req_wdata;
         cur.be    = req_be;
      end
   end

   // 33-bit offset: a borrow (addr below base) lands above SPAN, so one
   // compare covers both ends of the window.
   assign off = {1'b0, cur.addr} - {1'b0, BASE_ADDR};
   assign err = (cur.addr[1:0] != 2'b00) || (off >= SPAN);
   assign idx = off[IW+1:2];

   assign enter_resp = (state == IDLE && accept && LATENCY == 0) ||
                       (state == WAIT && cnt == 4'd0);
   // Reset gating keeps an aborted transaction from committing its store.
   assign mem_we     = enter_resp && cur.we && !err && !reset;

   mem_array_be #(.DEPTH(DEPTH)) u_mem (
      .clk (clk),
      .we  (mem_we),
      .be  (cur.be),
      .idx (idx),
      .wd  (cur.wdata),
      .rd  (rd)
   );

   // FSM: state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // FSM: next state
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (accept) state_nxt = (LATENCY == 0) ? RESP : WAIT;
         WAIT:    if (cnt == 4'd0) state_nxt = RESP;
         RESP:    if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      req_ready = (state == IDLE);
      rsp_valid = (state == RESP);
   end

   // Request capture and wait counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         req_q <= '0;
         cnt   <= '0;
      end else if (state == IDLE) begin
         if (accept) begin
            req_q <= cur;
            cnt   <= 4'(LATENCY - 1);
         end
      end else if (state == WAIT && cnt != 4'd0) begin
         cnt <= cnt - 4'd1;
      end
   end

   // Response registers load once, on entry to RESP, and hold until the
   // next access.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else if (enter_resp) begin
         rsp_err   <= err;
         rsp_rdata <= (err || cur.we) ? 32'h0 : rd;
      end
   end

endmodule
